// File: rtl/sha256_pad_stream.sv
// Streaming SHA-256 message padder: byte beats in, padded big-endian 32-bit words out, 16 per block.
// Define SHA_PAD_LENCHK_EN to enable the sticky length-overflow flag on err.
module sha256_pad_stream #(
    parameter int unsigned IN_BYTES = 1,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*IN_BYTES-1:0]   in_data,
    input  logic                    in_last,
    input  logic [2:0]              in_nbytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [3:0]              out_widx,
    output logic                    out_blast,
    output logic                    out_mlast,
    output logic                    err
);

    localparam int unsigned IN_W = 8 * IN_BYTES;

    localparam logic [2:0] S_DATA = 3'd0;
    localparam logic [2:0] S_PAD  = 3'd1;
    localparam logic [2:0] S_ZERO = 3'd2;
    localparam logic [2:0] S_LENH = 3'd3;
    localparam logic [2:0] S_LENL = 3'd4;

    logic [2:0]        r_state;
    logic [31:0]       r_acc;
    logic [1:0]        r_bpos;
    logic [LEN_W-1:0]  r_cnt;
    logic [3:0]        r_widx;
    logic [31:0]       r_out_data;
    logic              r_out_valid;
    logic [3:0]        r_out_widx;
    logic              r_out_blast;
    logic              r_out_mlast;

    logic [2:0]        w_state_nxt;
    logic [31:0]       w_acc_nxt;
    logic [1:0]        w_bpos_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [3:0]        w_widx_nxt;
    logic [31:0]       w_out_data_nxt;
    logic              w_out_valid_nxt;
    logic [3:0]        w_out_widx_nxt;
    logic              w_out_blast_nxt;
    logic              w_out_mlast_nxt;

    logic              w_load_ok;
    logic              w_accept;
    logic [31:0]       w_in32;
    logic [2:0]        w_nvalid;
    logic [2:0]        w_fill;
    logic [31:0]       w_merged;
    logic [63:0]       w_bitlen;
    logic [LEN_W-1:0]  w_cnt_sum;
    logic              w_emit;
    logic [31:0]       w_word;

    assign w_load_ok = !r_out_valid || out_ready;
    assign in_ready  = rst && (r_state == S_DATA) && w_load_ok;
    assign w_accept  = in_valid && in_ready;

    // Beat bytes MSB-aligned in a 32-bit view; w_fill is the byte position after this beat.
    assign w_in32   = 32'(in_data) << (32 - IN_W);
    assign w_nvalid = in_last ? in_nbytes : 3'(IN_BYTES);
    assign w_fill   = 3'(r_bpos) + w_nvalid;
    assign w_bitlen = 64'({r_cnt, 3'b000});

`ifdef SHA_PAD_LENCHK_EN
    logic w_cnt_carry;
    logic r_err;
    logic w_err_nxt;
    assign {w_cnt_carry, w_cnt_sum} = {1'b0, r_cnt} + (LEN_W+1)'(w_nvalid);
    assign err = r_err;
`else
    assign w_cnt_sum = r_cnt + LEN_W'(w_nvalid);
    assign err = 1'b0;
`endif

    // Merge valid beat bytes at the byte pointer; a last beat appends 0x80 if the word has room.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(r_bpos) && k < int'(w_fill)) begin
                w_merged[31-8*k -: 8] = w_in32[31-8*(k-int'(r_bpos)) -: 8];
            end
        end
        if (in_last && (w_fill < 3'd4)) begin
            w_merged[31-8*int'(w_fill) -: 8] = 8'h80;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_bpos_nxt      = r_bpos;
        w_cnt_nxt       = r_cnt;
        w_widx_nxt      = r_widx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_out_widx_nxt  = r_out_widx;
        w_out_blast_nxt = r_out_blast;
        w_out_mlast_nxt = r_out_mlast;
        w_emit          = 1'b0;
        w_word          = 32'h0000_0000;
`ifdef SHA_PAD_LENCHK_EN
        w_err_nxt       = r_err;
`endif

        case (r_state)
            S_DATA: begin
                if (w_accept) begin
                    w_cnt_nxt = w_cnt_sum;
`ifdef SHA_PAD_LENCHK_EN
                    if (w_cnt_carry) begin
                        w_err_nxt = 1'b1;
                    end
`endif
                    if (in_last || (w_fill >= 3'd4)) begin
                        w_emit     = 1'b1;
                        w_word     = w_merged;
                        w_acc_nxt  = 32'h0000_0000;
                        w_bpos_nxt = 2'd0;
                    end else begin
                        w_acc_nxt  = w_merged;
                        w_bpos_nxt = 2'(w_fill);
                    end
                    if (in_last) begin
                        if (w_fill >= 3'd4) begin
                            w_state_nxt = S_PAD;
                        end else if (r_widx == 4'd13) begin
                            w_state_nxt = S_LENH;
                        end else begin
                            w_state_nxt = S_ZERO;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_load_ok) begin
                    w_emit      = 1'b1;
                    w_word      = 32'h8000_0000;
                    w_state_nxt = (r_widx == 4'd13) ? S_LENH : S_ZERO;
                end
            end
            S_ZERO: begin
                // Zero fill always ends on index 13, wrapping into a new block if needed.
                if (w_load_ok) begin
                    w_emit = 1'b1;
                    if (r_widx == 4'd13) begin
                        w_state_nxt = S_LENH;
                    end
                end
            end
            S_LENH: begin
                if (w_load_ok) begin
                    w_emit      = 1'b1;
                    w_word      = w_bitlen[63:32];
                    w_state_nxt = S_LENL;
                end
            end
            S_LENL: begin
                if (w_load_ok) begin
                    w_emit      = 1'b1;
                    w_word      = w_bitlen[31:0];
                    w_cnt_nxt   = '0;
                    w_bpos_nxt  = 2'd0;
                    w_state_nxt = S_DATA;
                end
            end
            default: begin
                w_state_nxt = S_DATA;
            end
        endcase

        if (w_emit) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_word;
            w_out_widx_nxt  = r_widx;
            w_out_blast_nxt = (r_widx == 4'd15);
            w_out_mlast_nxt = (r_state == S_LENL);
            w_widx_nxt      = (r_state == S_LENL) ? 4'd0 : r_widx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_DATA;
            r_acc       <= 32'h0000_0000;
            r_bpos      <= 2'd0;
            r_cnt       <= '0;
            r_widx      <= 4'd0;
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_out_widx  <= 4'd0;
            r_out_blast <= 1'b0;
            r_out_mlast <= 1'b0;
`ifdef SHA_PAD_LENCHK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_bpos      <= w_bpos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_widx      <= w_widx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_widx  <= w_out_widx_nxt;
            r_out_blast <= w_out_blast_nxt;
            r_out_mlast <= w_out_mlast_nxt;
`ifdef SHA_PAD_LENCHK_EN
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_widx  = r_out_widx;
    assign out_blast = r_out_blast;
    assign out_mlast = r_out_mlast;

endmodule

// File: tb/tb_sha256_pad_stream.sv
// Self-checking bench for sha256_pad_stream: three instances (1-byte, 4-byte, 6-bit counter)
// driven through a shared stimulus path and checked against a byte-queue padding model.
module tb_sha256_pad_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        out_ready;
    logic [1:0]  sel;

    logic        w_rdy [3];
    logic        w_ov  [3];
    logic [31:0] w_od  [3];
    logic [3:0]  w_ow  [3];
    logic        w_bl  [3];
    logic        w_ml  [3];
    logic        w_er  [3];

    logic        m_rdy, m_ov, m_bl, m_ml, m_err;
    logic [31:0] m_od;
    logic [3:0]  m_ow;

    int checks = 0;
    int errors = 0;

    logic [31:0] e_words [$];
    logic [31:0] g_data  [$];
    logic [3:0]  g_widx  [$];
    logic        g_blast [$];
    logic        g_mlast [$];
    int          g_timeout, g_lat_beat, g_lat_word, g_bp_cycles, g_bp_viol;
    logic        g_err_pre;

    always #5 clk = ~clk;

    sha256_pad_stream #(.IN_BYTES(1), .LEN_W(16)) u_b1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd0)), .in_ready(w_rdy[0]),
        .in_data(in_data[31:24]), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(w_ov[0]), .out_ready(out_ready), .out_data(w_od[0]), .out_widx(w_ow[0]),
        .out_blast(w_bl[0]), .out_mlast(w_ml[0]), .err(w_er[0]));

    sha256_pad_stream #(.IN_BYTES(4), .LEN_W(16)) u_b4 (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd1)), .in_ready(w_rdy[1]),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(w_ov[1]), .out_ready(out_ready), .out_data(w_od[1]), .out_widx(w_ow[1]),
        .out_blast(w_bl[1]), .out_mlast(w_ml[1]), .err(w_er[1]));

    sha256_pad_stream #(.IN_BYTES(1), .LEN_W(6)) u_ov (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd2)), .in_ready(w_rdy[2]),
        .in_data(in_data[31:24]), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(w_ov[2]), .out_ready(out_ready), .out_data(w_od[2]), .out_widx(w_ow[2]),
        .out_blast(w_bl[2]), .out_mlast(w_ml[2]), .err(w_er[2]));

    always_comb begin
        m_rdy = w_rdy[0]; m_ov = w_ov[0]; m_od = w_od[0]; m_ow = w_ow[0];
        m_bl  = w_bl[0];  m_ml = w_ml[0]; m_err = w_er[0];
        case (sel)
            2'd1: begin
                m_rdy = w_rdy[1]; m_ov = w_ov[1]; m_od = w_od[1]; m_ow = w_ow[1];
                m_bl  = w_bl[1];  m_ml = w_ml[1]; m_err = w_er[1];
            end
            2'd2: begin
                m_rdy = w_rdy[2]; m_ov = w_ov[2]; m_od = w_od[2]; m_ow = w_ow[2];
                m_bl  = w_bl[2];  m_ml = w_ml[2]; m_err = w_er[2];
            end
            default: ;
        endcase
    end

    // Reference: textbook SHA-256 padding of a byte queue, length taken modulo 2^lenw bytes.
    function automatic void build_exp(input byte unsigned msg[$], input int lenw);
        byte unsigned q[$];
        logic [63:0]  bits;
        q = msg;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        bits = (64'(msg.size()) & ((64'd1 << lenw) - 64'd1)) << 3;
        for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
        e_words.delete();
        for (int i = 0; i < int'(q.size()); i += 4) e_words.push_back({q[i], q[i+1], q[i+2], q[i+3]});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one message as beats and records every consumed output word until out_mlast.
    task automatic run_msg(input byte unsigned msg[$], input int bpr, input bit empty_tail,
                           input int bp_mode, input int gap_pct);
        logic [31:0] bd[$];
        bit          bl[$];
        int          bn[$];
        int          n, pos, take, bi, cyc, stall_left;
        bit          done, stalled;
        logic [31:0] d, hold_d;
        logic [3:0]  hold_w;
        logic        hold_bl, hold_ml;
        n = msg.size(); pos = 0;
        forever begin
            take = (n - pos >= bpr) ? bpr : n - pos;
            d = $urandom();
            for (int j = 0; j < take; j++) d[31-8*j -: 8] = msg[pos+j];
            pos += take;
            if (take < bpr || (pos == n && !empty_tail)) begin
                bd.push_back(d); bl.push_back(1'b1); bn.push_back(take);
                break;
            end
            bd.push_back(d); bl.push_back(1'b0); bn.push_back(take);
        end
        g_data.delete(); g_widx.delete(); g_blast.delete(); g_mlast.delete();
        g_lat_beat = -1; g_lat_word = -1; g_bp_cycles = 0; g_bp_viol = 0; g_err_pre = 1'bx;
        bi = 0; cyc = 0; stall_left = 0; done = 0; stalled = 0;
        hold_d = '0; hold_w = '0; hold_bl = 0; hold_ml = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (bp_mode == 2 && !stalled && m_ov && m_ow == 4'd7) begin
                stall_left = 5; stalled = 1;
                hold_d = m_od; hold_w = m_ow; hold_bl = m_bl; hold_ml = m_ml;
            end
            if (stall_left > 0) out_ready = 1'b0;
            else if (bp_mode == 1) out_ready = ($urandom_range(99) < 70);
            else out_ready = 1'b1;
            if (bi < int'(bd.size()) && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1; in_data = bd[bi]; in_last = bl[bi];
                in_nbytes = bl[bi] ? 3'(bn[bi]) : 3'($urandom_range(7));
            end else begin
                in_valid = 1'b0; in_data = $urandom(); in_last = 1'($urandom_range(1));
                in_nbytes = 3'($urandom_range(7));
            end
            #1;
            if (stall_left > 0) begin
                g_bp_cycles++;
                if (m_rdy || !m_ov || m_od !== hold_d || m_ow !== hold_w || m_bl !== hold_bl || m_ml !== hold_ml)
                    g_bp_viol++;
                stall_left--;
            end
            if (in_valid && m_rdy) begin
                if (in_last) g_lat_beat = cyc;
                if (bi == int'(bd.size()) - 1) g_err_pre = m_err;
                bi++;
            end
            if (m_ov && g_lat_word < 0) g_lat_word = cyc;
            if (m_ov && out_ready) begin
                g_data.push_back(m_od); g_widx.push_back(m_ow);
                g_blast.push_back(m_bl); g_mlast.push_back(m_ml);
                if (m_ml) done = 1;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        g_timeout = done ? 0 : 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++; if (m_rdy !== 1'b0)        begin errors++; $display("FAIL reset_in_ready[%0d] got %b exp 0", s, m_rdy); end
            checks++; if (m_ov !== 1'b0)         begin errors++; $display("FAIL reset_out_valid[%0d] got %b exp 0", s, m_ov); end
            checks++; if (m_od !== 32'h0)        begin errors++; $display("FAIL reset_out_data[%0d] got %h exp 0", s, m_od); end
            checks++; if (m_ow !== 4'h0)         begin errors++; $display("FAIL reset_out_widx[%0d] got %0d exp 0", s, m_ow); end
            checks++; if (m_bl !== 1'b0 || m_ml !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d] got %b%b exp 00", s, m_bl, m_ml); end
            checks++; if (m_err !== 1'b0)        begin errors++; $display("FAIL reset_err[%0d] got %b exp 0", s, m_err); end
        end
        rst = 1'b1;
        sel = 2'd0;
    endtask

    task automatic test_abc();
        byte unsigned msg[$];
        msg = '{8'h61, 8'h62, 8'h63};
        sel = 2'd0;
        build_exp(msg, 16);
        run_msg(msg, 1, 0, 0, 0);
        checks++; if (g_timeout != 0) begin errors++; $display("FAIL abc_timeout got %0d exp 0", g_timeout); end
        checks++; if (g_data.size() != 16) begin errors++; $display("FAIL abc_len got %0d exp 16", g_data.size()); end
        for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
            checks++;
            if (g_data[i] !== e_words[i] || g_widx[i] !== 4'(i % 16) || g_blast[i] !== (i % 16 == 15) ||
                g_mlast[i] !== (i == int'(e_words.size()) - 1)) begin
                errors++;
                $display("FAIL abc_word%0d got %h/%0d/%b/%b exp %h/%0d", i, g_data[i], g_widx[i], g_blast[i], g_mlast[i], e_words[i], i % 16);
            end
        end
        if (g_data.size() == 16) begin
            checks++; if (g_data[0] !== 32'h6162_6380) begin errors++; $display("FAIL abc_w0 got %h exp 61626380", g_data[0]); end
            checks++; if (g_data[15] !== 32'h0000_0018) begin errors++; $display("FAIL abc_w15 got %h exp 00000018", g_data[15]); end
        end
        checks++; if (g_lat_word != g_lat_beat + 1) begin errors++; $display("FAIL abc_latency got %0d exp %0d", g_lat_word, g_lat_beat + 1); end
    endtask

    task automatic test_block_boundary();
        byte unsigned msg[$];
        logic [31:0]  last_exp;
        int           nw;
        sel = 2'd0;
        for (int t = 0; t < 2; t++) begin
            msg.delete();
            for (int i = 0; i < 55 + t; i++) msg.push_back(8'($urandom_range(255)));
            nw = (t == 0) ? 16 : 32;
            last_exp = (t == 0) ? 32'h0000_01B8 : 32'h0000_01C0;
            build_exp(msg, 16);
            run_msg(msg, 1, 0, 1, 20);
            checks++; if (g_timeout != 0) begin errors++; $display("FAIL len%0d_timeout got %0d exp 0", 55 + t, g_timeout); end
            checks++; if (int'(g_data.size()) != nw) begin errors++; $display("FAIL len%0d_words got %0d exp %0d", 55 + t, g_data.size(), nw); end
            for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
                checks++;
                if (g_data[i] !== e_words[i] || g_widx[i] !== 4'(i % 16) || g_blast[i] !== (i % 16 == 15) ||
                    g_mlast[i] !== (i == int'(e_words.size()) - 1)) begin
                    errors++;
                    $display("FAIL len%0d_word%0d got %h/%0d/%b/%b exp %h", 55 + t, i, g_data[i], g_widx[i], g_blast[i], g_mlast[i], e_words[i]);
                end
            end
            if (int'(g_data.size()) == nw) begin
                checks++;
                if (g_data[nw-1] !== last_exp) begin errors++; $display("FAIL len%0d_final got %h exp %h", 55 + t, g_data[nw-1], last_exp); end
            end
        end
    endtask

    task automatic test_empty();
        byte unsigned msg[$];
        sel = 2'd1;
        build_exp(msg, 16);
        run_msg(msg, 4, 0, 0, 0);
        checks++; if (g_timeout != 0 || g_data.size() != 16) begin errors++; $display("FAIL empty_words got %0d exp 16", g_data.size()); end
        for (int i = 0; i < int'(g_data.size()) && i < 16; i++) begin
            checks++;
            if (g_data[i] !== ((i == 0) ? 32'h8000_0000 : 32'h0) || g_widx[i] !== 4'(i) || g_mlast[i] !== (i == 15)) begin
                errors++; $display("FAIL empty_word%0d got %h/%0d/%b", i, g_data[i], g_widx[i], g_mlast[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        byte unsigned msg[$];
        sel = 2'd1;
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(255)));
        build_exp(msg, 16);
        run_msg(msg, 4, 0, 2, 0);
        checks++; if (g_timeout != 0 || g_data.size() != 32) begin errors++; $display("FAIL bp_words got %0d exp 32", g_data.size()); end
        checks++; if (g_bp_cycles != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 5", g_bp_cycles); end
        checks++; if (g_bp_viol != 0) begin errors++; $display("FAIL bp_hold_violations got %0d exp 0", g_bp_viol); end
        for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
            checks++;
            if (g_data[i] !== e_words[i] || g_blast[i] !== (i % 16 == 15)) begin
                errors++; $display("FAIL bp_word%0d got %h exp %h", i, g_data[i], e_words[i]);
            end
        end
        if (g_data.size() == 32) begin
            checks++; if (g_data[31] !== 32'h0000_0200) begin errors++; $display("FAIL bp_final got %h exp 00000200", g_data[31]); end
        end
    endtask

    task automatic test_reset_mid();
        byte unsigned msg[$];
        sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
            in_data = {8'($urandom_range(255)), 24'h0};
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        msg = '{8'h61, 8'h62, 8'h63};
        build_exp(msg, 16);
        run_msg(msg, 1, 0, 0, 0);
        checks++; if (g_timeout != 0 || g_data.size() != 16) begin errors++; $display("FAIL rstmid_words got %0d exp 16", g_data.size()); end
        for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
            checks++;
            if (g_data[i] !== e_words[i] || g_widx[i] !== 4'(i) || g_mlast[i] !== (i == 15)) begin
                errors++; $display("FAIL rstmid_word%0d got %h exp %h", i, g_data[i], e_words[i]);
            end
        end
    endtask

    task automatic test_overflow();
        byte unsigned msg[$];
        logic         err_exp;
`ifdef SHA_PAD_LENCHK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        do_reset();
        sel = 2'd2;
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(255)));
        build_exp(msg, 6);
        run_msg(msg, 1, 0, 1, 20);
        checks++; if (g_timeout != 0 || g_data.size() != 32) begin errors++; $display("FAIL ovf_words got %0d exp 32", g_data.size()); end
        for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
            checks++;
            if (g_data[i] !== e_words[i]) begin errors++; $display("FAIL ovf_word%0d got %h exp %h", i, g_data[i], e_words[i]); end
        end
        if (g_data.size() == 32) begin
            checks++; if (g_data[31] !== 32'h0) begin errors++; $display("FAIL ovf_final got %h exp 00000000", g_data[31]); end
        end
        checks++; if (g_err_pre !== 1'b0) begin errors++; $display("FAIL ovf_err_before got %b exp 0", g_err_pre); end
        @(negedge clk);
        checks++; if (m_err !== err_exp) begin errors++; $display("FAIL ovf_err_after got %b exp %b", m_err, err_exp); end
        sel = 2'd0;
    endtask

    task automatic test_random();
        byte unsigned msg[$];
        int           len, s;
        bit           tail;
        for (int it = 0; it < 14; it++) begin
            s    = $urandom_range(1);
            sel  = 2'(s);
            len  = $urandom_range(140);
            tail = 1'($urandom_range(1));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(255)));
            build_exp(msg, 16);
            run_msg(msg, (s == 1) ? 4 : 1, tail, (it < 4) ? 0 : 1, (it < 4) ? 0 : 25);
            checks++;
            if (g_timeout != 0 || g_data.size() != e_words.size()) begin
                errors++; $display("FAIL rand%0d_words len %0d got %0d exp %0d", it, len, g_data.size(), e_words.size());
            end
            for (int i = 0; i < int'(g_data.size()) && i < int'(e_words.size()); i++) begin
                checks++;
                if (g_data[i] !== e_words[i] || g_widx[i] !== 4'(i % 16) || g_blast[i] !== (i % 16 == 15) ||
                    g_mlast[i] !== (i == int'(e_words.size()) - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d got %h/%0d/%b/%b exp %h", it, i, g_data[i], g_widx[i], g_blast[i], g_mlast[i], e_words[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = 3'd0;
        out_ready = 1'b1; sel = 2'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_abc();
        test_block_boundary();
        test_empty();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/sha256_pad_stream.md
# sha256_pad_stream

Streaming SHA-256 message padder, parametrised successor to the single-block, RAM-resident `pad` stage. It accepts a message of any length as a byte stream (1, 2 or 4 bytes per beat) and emits the padded message as big-endian 32-bit words, 16 per 512-bit block. Each block gets a word index and block/message-end flags, so the compression core consumes words directly without a shared RAM. Multi-block messages are handled natively.

## Interface
- `IN_BYTES`, default 1: bytes per input beat; legal values are 1, 2 and 4.
- `LEN_W`, default 16: width of the message byte counter. The bit length is `{count, 3'b000}`, zero-extended to 64 bits. Legal range is 3..61.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  8*IN_BYTES  message bytes; the first byte is in the MSBs.
- `in_last`  in  1  final beat of the message.
- `in_nbytes`  in  3  valid bytes on the last beat, 0..IN_BYTES, MSB-aligned; ignored when `in_last` = 0.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  output word consumed when `out_valid && out_ready`.
- `out_data`  out  32  padded message word, big-endian.
- `out_widx`  out  4  word index within the block, 0..15.
- `out_blast`  out  1  high when `out_widx` = 15.
- `out_mlast`  out  1  last word of the final block.
- `err`  out  1  length overflow, sticky (see Configuration).

## Operation
**States:** DATA, PAD, ZERO, LENH, LENL.

**Datapath registers:**
- 32-bit accumulator `acc` with byte pointer `bpos` (0..3).
- Output register (`out_data`, `out_valid`).
- Word index `widx`.
- Byte counter `cnt` (LEN_W bits).

**DATA state:**
- `in_ready = (state == DATA) && (!out_valid || out_ready)`.
- Each accepted beat shifts its bytes into `acc` at `bpos`. Beat alignment guarantees no word straddles a beat.
- When `acc` fills, it loads the output register and `widx` increments modulo 16.
- Non-last beats add IN_BYTES to `cnt`.
- A last beat adds `in_nbytes` to `cnt`. Its bytes are merged, then byte `0x80` is appended at the next position in the same cycle, and the remaining bytes of that word are zero. A 4-byte last beat with `in_nbytes` = 4 on a full word sends `0x80` to a new word: go to PAD.
- `in_nbytes` = 0 on a last beat (including the empty message) contributes only `0x80`.

**PAD state:** emit `0x80000000` as one word.

**ZERO state:** emit `0x00000000` words.
- If the `0x80` word landed at index ≤ 13, fill until index 13 is emitted.
- If it landed at index 14 or 15, fill to index 15, then indices 0..13 of a new block.

**LENH / LENL:**
- LENH emits the upper 32 bits of the 64-bit bit length at index 14.
- LENL emits the lower 32 bits at index 15 with `out_mlast` = 1.
- On the LENL handshake, clear `cnt`, `bpos` and `widx`, then return to DATA.

**Arithmetic:** `cnt` wraps modulo 2^LEN_W. The bit length is formed from the wrapped `cnt` (plus `err`, see Configuration).

## Timing
**Reset values** (`rst` = 0 at a clock edge):
- `out_valid` = 0, `in_ready` = 0, `out_data` = 0, `out_widx` = 0, `out_blast` = 0, `out_mlast` = 0, `err` = 0, state = DATA.

**Reset mid-message:** the partial message is discarded; the first beat after reset starts a new message.

**Latency:** a word appears on `out_data` one cycle after the beat that completes it.

**Throughput:**
- Padding states (PAD, ZERO, LENH, LENL) produce one word per cycle while `out_ready` = 1.
- For back-to-back messages, the first beat of the next message is accepted in the cycle after the LENL handshake.

**Backpressure:**
- While `out_valid && !out_ready`, `out_data`, `out_widx` and the flags hold stable, and `in_ready` = 0.
- `in_ready` has a combinational dependence on `out_ready`.

**Simultaneous input and output handshakes:** a new word may load in the same cycle the previous word is consumed, with no bubble.

## Configuration
**`SHA_PAD_LENCHK_EN` defined:**
- `err` sets when an `cnt` addition carries out of LEN_W bits, and stays set until reset.
- Padding still completes, using the wrapped length.

**Not defined:** `err` is tied to 0 and the counter wraps silently.

## Test plan
- **"abc", IN_BYTES=1:** 3 beats, last with `in_nbytes`=1 → word0 `0x61626380`, words 1..14 `0x00000000`, word15 `0x00000018`; `out_mlast` and `out_blast` on word 15 only.
- **55-byte and 56-byte messages:**
  - 55 bytes → one block, word15 `0x000001B8`.
  - 56 bytes → two blocks (32 words), `out_blast` at words 15 and 31, final word `0x000001C0`.
- **Empty message, IN_BYTES=4:** single beat with `in_last`=1, `in_nbytes`=0 → word0 `0x80000000`, remaining words 0, word15 `0x00000000`, `out_mlast`=1.
- **Backpressure, IN_BYTES=4, 64-byte message:**
  - Hold `out_ready`=0 for 5 cycles at word 7 → word 7 stable and `in_ready`=0 throughout.
  - Second block is all padding, word31 `0x00000200`.
- **Reset mid-message:** `rst`=0 for one cycle after 10 bytes, then send "abc" → outputs identical to the first scenario.
- **Length overflow, `SHA_PAD_LENCHK_EN`, LEN_W=6:** 64-byte message → `err`=1 after the 64th byte, final word `0x00000000`. Without the macro, `err` stays 0.
